// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: control-transfer opcodes,
// array geometry and the packed entry layout.
package branch_target_buffer_pkg;

    localparam logic [6:0] B_type = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] R_type = 7'b0110011;

    localparam int BTB_ENTRIES = 16;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);

    // Tag covers every PC bit above the index; pc[1:0] is never stored.
    function automatic int tag_width(input int idx_w);
        return 30 - idx_w;
    endfunction

    localparam int TAG_W = tag_width(BTB_IDX_W);

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_WEAK  = 2'b10;
    localparam logic [1:0] CTR_STRONG = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } btb_entry_t;

    localparam btb_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: 32'h0, ctr: CTR_RESET};

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Two-bit saturating up/down counter next-state logic used when training
// the direction of a conditional branch.
module sat_counter2 (
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Saturate at 11 on taken and at 00 on not-taken.
    always_comb begin
        ctr_o = ctr_i;
        case ({taken_i, ctr_i})
            3'b1_00: ctr_o = 2'b01;
            3'b1_01: ctr_o = 2'b10;
            3'b1_10: ctr_o = 2'b11;
            3'b1_11: ctr_o = 2'b11;
            3'b0_00: ctr_o = 2'b00;
            3'b0_01: ctr_o = 2'b00;
            3'b0_10: ctr_o = 2'b01;
            3'b0_11: ctr_o = 2'b10;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup on the
// fetch PC, training from the resolved EX-stage control transfer.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter  int ENTRIES = BTB_ENTRIES,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_pc_sel_BTB,
    output logic [31:0] o_pc_BTB,
    output logic        o_btb_hit,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic [6:0]  i_ex_opcode,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target
);

    btb_entry_t mem_q [ENTRIES];

    logic [IDX_W-1:0] if_idx_s;
    logic [TAG_W-1:0] if_tag_s;
    btb_entry_t       if_ent_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic [TAG_W-1:0] ex_tag_s;
    btb_entry_t       ex_ent_s;
    logic             ex_hit_s;
    logic             is_br_s;
    logic             is_jmp_s;
    logic [1:0]       ctr_step_s;
    logic             wr_en_d;
    btb_entry_t       entry_d;

    assign if_idx_s = i_if_pc[IDX_W+1:2];
    assign if_tag_s = TAG_W'(i_if_pc >> (IDX_W + 2));
    assign if_ent_s = mem_q[if_idx_s];

    assign ex_idx_s = i_ex_pc[IDX_W+1:2];
    assign ex_tag_s = TAG_W'(i_ex_pc >> (IDX_W + 2));
    assign ex_ent_s = mem_q[ex_idx_s];
    assign ex_hit_s = ex_ent_s.valid && (ex_ent_s.tag == ex_tag_s);
    assign is_br_s  = (i_ex_opcode == B_type);
    assign is_jmp_s = (i_ex_opcode == JAL) || (i_ex_opcode == JALR);

    sat_counter2 u_sat_counter2 (
        .ctr_i   (ex_ent_s.ctr),
        .taken_i (i_ex_taken),
        .ctr_o   (ctr_step_s)
    );

    // Lookup path: reads pre-update contents, so same-cycle training is invisible.
    always_comb begin
        o_btb_hit    = if_ent_s.valid && (if_ent_s.tag == if_tag_s);
        o_pc_sel_BTB = o_btb_hit && if_ent_s.ctr[1];
        if (o_pc_sel_BTB) begin
            o_pc_BTB = if_ent_s.target;
        end else begin
            o_pc_BTB = i_if_pc + 32'd4;
        end
    end

    // Training decision: refresh on hit, allocate only on a taken miss.
    always_comb begin
        wr_en_d = 1'b0;
        entry_d = ex_ent_s;
        if (i_ex_valid && (is_br_s || is_jmp_s)) begin
            if (ex_hit_s) begin
                wr_en_d     = 1'b1;
                entry_d.ctr = is_jmp_s ? CTR_STRONG : ctr_step_s;
                if (i_ex_taken) begin
                    entry_d.target = i_ex_target;
                end else begin
                    entry_d.target = ex_ent_s.target;
                end
            end else if (i_ex_taken) begin
                wr_en_d        = 1'b1;
                entry_d.valid  = 1'b1;
                entry_d.tag    = ex_tag_s;
                entry_d.target = i_ex_target;
                entry_d.ctr    = is_jmp_s ? CTR_STRONG : CTR_WEAK;
            end else begin
                wr_en_d = 1'b0;
            end
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Flop array so a single reset clears every entry at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= ENTRY_RESET;
            end
        end else if (wr_en_d) begin
            mem_q[ex_idx_s] <= entry_d;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: training via EX inputs, lookups
// checked against expected hit/taken/next-PC values queued with the stimulus.
module tb_branch_target_buffer;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_R    = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic        pc_sel;
    logic [31:0] pc_btb;
    logic        btb_hit;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic [6:0]  ex_opcode = 7'h0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        hit;
        logic        sel;
        logic [31:0] npc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_if_pc      (if_pc),
        .o_pc_sel_BTB (pc_sel),
        .o_pc_BTB     (pc_btb),
        .o_btb_hit    (btb_hit),
        .i_ex_valid   (ex_valid),
        .i_ex_pc      (ex_pc),
        .i_ex_opcode  (ex_opcode),
        .i_ex_taken   (ex_taken),
        .i_ex_target  (ex_target)
    );

    always #5 clk = ~clk;

    // One EX-stage resolution lasting exactly one rising edge.
    task automatic ex_drive(input logic [6:0] op, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt, input logic vld);
        @(negedge clk);
        ex_opcode = op; ex_pc = pc; ex_taken = tk; ex_target = tgt; ex_valid = vld;
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    task automatic push_exp(input string nm, input logic [31:0] pc, input logic h,
                            input logic s, input logic [31:0] npc);
        exp_t e;
        e.name = nm; e.pc = pc; e.hit = h; e.sel = s; e.npc = npc;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        push_exp("reset_hold0", 32'h100, 1'b0, 1'b0, 32'h104);
        push_exp("reset_hold1", 32'h100, 1'b0, 1'b0, 32'h104);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        push_exp("reset_release", 32'h100, 1'b0, 1'b0, 32'h104);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
    endtask

    task automatic test_allocation();
        exp_t e;
        @(negedge clk);
        ex_opcode = OP_B; ex_pc = 32'h40; ex_taken = 1'b1; ex_target = 32'h80; ex_valid = 1'b1;
        if_pc = 32'h40;
        push_exp("alloc_same_cycle", 32'h40, 1'b0, 1'b0, 32'h44);
        #1;
        e = sb_q.pop_front();
        total++;
        if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
            bad++;
            $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                     e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
        end
        @(posedge clk);
        #1 ex_valid = 1'b0;
        push_exp("alloc_next_cycle", 32'h40, 1'b1, 1'b1, 32'h80);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
    endtask

    task automatic test_hysteresis();
        // ctr path from 10: NT->01, NT->00, NT->00, T->01, T->10
        logic tk_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic sel_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            ex_drive(OP_B, 32'h40, tk_tab[i], 32'h80, 1'b1);
            push_exp($sformatf("hyst_step%0d", i), 32'h40, 1'b1, sel_tab[i],
                     sel_tab[i] ? 32'h80 : 32'h44);
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
    endtask

    task automatic test_gating();
        exp_t e;
        ex_drive(OP_B, 32'h200, 1'b0, 32'h900, 1'b1);
        ex_drive(OP_JAL, 32'h300, 1'b1, 32'h1000, 1'b0);
        push_exp("nt_miss_no_alloc", 32'h200, 1'b0, 1'b0, 32'h204);
        push_exp("invalid_no_alloc", 32'h300, 1'b0, 1'b0, 32'h304);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
        ex_drive(OP_JAL, 32'h300, 1'b1, 32'h1000, 1'b1);
        push_exp("jal_alloc", 32'h300, 1'b1, 1'b1, 32'h1000);
        // A not-taken hit must keep the target and, from 11, stay predicted taken.
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
        ex_drive(OP_B, 32'h300, 1'b0, 32'h7777, 1'b1);
        push_exp("jal_ctr_strong", 32'h300, 1'b1, 1'b1, 32'h1000);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
    endtask

    task automatic test_aliasing();
        exp_t e;
        ex_drive(OP_B, 32'h40, 1'b1, 32'h80, 1'b1);
        ex_drive(OP_JALR, 32'h80, 1'b1, 32'h500, 1'b1);
        push_exp("alias_old_miss", 32'h40, 1'b0, 1'b0, 32'h44);
        push_exp("alias_new_hit", 32'h80, 1'b1, 1'b1, 32'h500);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
    endtask

    task automatic test_wrap_nonctl();
        exp_t e;
        ex_drive(OP_R, 32'h80, 1'b1, 32'h999, 1'b1);
        ex_drive(OP_R, 32'h600, 1'b1, 32'h999, 1'b1);
        push_exp("wrap_plus4", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        push_exp("rtype_hit_kept", 32'h80, 1'b1, 1'b1, 32'h500);
        push_exp("rtype_no_alloc", 32'h600, 1'b0, 1'b0, 32'h604);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        // alloc ctr 10, taken hit -> 11 with new target, not-taken -> 10
        ex_drive(OP_B, 32'h10, 1'b1, 32'h20, 1'b1);
        ex_drive(OP_B, 32'h10, 1'b1, 32'h24, 1'b1);
        ex_drive(OP_B, 32'h10, 1'b0, 32'h28, 1'b1);
        push_exp("b2b_target_ctr", 32'h10, 1'b1, 1'b1, 32'h24);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
    endtask

    task automatic test_reset_mid_update();
        exp_t e;
        @(negedge clk);
        ex_opcode = OP_JAL; ex_pc = 32'h80; ex_taken = 1'b1; ex_target = 32'h900; ex_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 ex_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        push_exp("rst_clears_80", 32'h80, 1'b0, 1'b0, 32'h84);
        push_exp("rst_clears_300", 32'h300, 1'b0, 1'b0, 32'h304);
        push_exp("rst_clears_10", 32'h10, 1'b0, 1'b0, 32'h14);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk); if_pc = e.pc; #1;
            total++;
            if (btb_hit !== e.hit || pc_sel !== e.sel || pc_btb !== e.npc) begin
                bad++;
                $display("FAIL %s: got hit=%b sel=%b pc=%h want hit=%b sel=%b pc=%h",
                         e.name, btb_hit, pc_sel, pc_btb, e.hit, e.sel, e.npc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_allocation();
        test_hysteresis();
        test_gating();
        test_aliasing();
        test_wrap_nonctl();
        test_back_to_back();
        test_reset_mid_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
